melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Programmable note scheduler that sequences the tone datapath (sine-clock generator plus PWM DACs). It holds a writable table of (pitch maxval, duration) entries. Each table slot is one note. At sample rate it steps through the notes and drives the pitch `maxval` to the sine clock generator. It also issues a restart strobe on every note change and mutes the DACs between notes and during rests. It replaces hard-coded melody arrays with a runtime-loadable, start/stop/loop-controlled player.

## Interface
Parameters:
- PITCH_BITWIDTH, 9, width of pitch maxval
- DUR_BITWIDTH, 13, width of duration in fs samples
- ADDR_BITWIDTH, 5, table address width (depth = 2**ADDR_BITWIDTH = 32)
- GAP_SAMPLES, 200, muted fs samples inserted after every note (0 = legato)

Ports:
- clk  in  1  system clock (10 MHz)
- reset  in  1  asynchronous, active-low reset
- fs_tick  in  1  one-cycle sample strobe (8 kHz, from fs clkgen)
- cfg_we  in  1  table write enable
- cfg_addr  in  ADDR_BITWIDTH  table write address
- cfg_pitch  in  PITCH_BITWIDTH  pitch maxval; 0 = rest
- cfg_dur  in  DUR_BITWIDTH  note duration in samples
- cfg_len  in  ADDR_BITWIDTH+1  number of notes to play (1..32)
- start  in  1  one-cycle start pulse
- stop  in  1  one-cycle abort pulse
- loop_en  in  1  repeat melody after last note
- pitch_maxval  out  PITCH_BITWIDTH  maxval for sine clkgen
- note_valid  out  1  1 = tone audible (gate DACs), 0 = mute
- note_start  out  1  one-cycle pulse at the first PLAY cycle of each note; restarts clkgen/sine
- cur_index  out  ADDR_BITWIDTH  index of note being played
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle pulse at natural end of a non-looped melody

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Counters 0.
  - Table contents undefined, not reset.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - cfg_we writes the table, one entry per cycle.
  - cfg_we is ignored while busy=1.
- start in IDLE:
  - Ignored when cfg_len=0 or cfg_len>32.
  - Otherwise latch cfg_len and loop_en, set idx=0, go to FETCH.
  - start while busy is ignored.
- FETCH:
  - One cycle; issues the table read.
  - Registered read data is valid on the next cycle, when the state becomes PLAY.
- On PLAY entry:
  - pitch_maxval <= entry pitch.
  - note_valid <= (pitch != 0).
  - note_start pulses.
  - cur_index <= idx.
  - Sample counter cleared.
- PLAY: on each fs_tick, the counter increments. The fs_tick where counter == dur-1 ends the note.
  - dur=0 is treated as 1.
  - At note end: note_valid <= 0. Go to GAP if GAP_SAMPLES>0, else advance.
- GAP: note_valid=0 and pitch_maxval held. The GAP_SAMPLES-th fs_tick advances.
- Advance:
  - If idx == len-1 and loop_en: idx <= 0, go to FETCH.
  - If idx == len-1 and not loop_en: done pulses, go to IDLE.
  - Otherwise idx++, go to FETCH.
- stop:
  - In any state, next cycle is IDLE: note_valid=0, busy=0, no done pulse.
  - pitch_maxval and cur_index hold their values.
  - stop has priority over start and over a note ending in the same cycle.
- loop_en is sampled only at start; changes mid-melody have no effect.
- Duration arithmetic is unsigned DUR_BITWIDTH. The sample counter has the same width and never wraps because dur ≤ 2**DUR_BITWIDTH-1.

## Timing
- start (cycle 0) → FETCH (cycle 1) → PLAY with note_start=1 and pitch valid (cycle 2). busy=1 from cycle 1.
- Note length is exactly dur fs_ticks in PLAY plus GAP_SAMPLES fs_ticks in GAP.
- Inter-note overhead is 2 clk cycles (advance + FETCH), negligible against 1250 clk per sample.
- fs_tick during a FETCH cycle or a PLAY-entry cycle is not counted. The fs_tick source guarantees that ticks are at least 3 cycles apart.
- done and busy: done is high for 1 cycle, in the same cycle busy falls to 0.
- Async reset assertion clears all state immediately; deassertion is synchronised externally.

## Structure
- `melody_pkg`:
  - state enum.
  - Default widths.
  - Note maxval constants: D=266, E=237, FIS=211, G=199, A=177, B=158, C=149, DHIGH=133.
  - Duration constants for a 1/8 note (2000), 1/4 note (4000), 3/8 note (6000) and 1/2 note (8000).
- Sub-module `note_table`:
  - 2**ADDR_BITWIDTH × (PITCH_BITWIDTH+DUR_BITWIDTH) RAM.
  - Synchronous write, registered read.
  - No reset.
- `melody_sequencer` contains the FSM, the sample counter, the gap counter and the index logic.

## Test plan
- Load 3 notes {G/4, A/2, B/3}, len=3, GAP=0, no loop, start → pitch_maxval 199, 177, 158. The fs_tick gaps between note_start pulses are exactly 4, 2 and 3. done pulses 3 ticks after the third note_start, and busy then falls.
- Same melody, GAP=2 → note_valid is low for exactly 2 fs_ticks between notes, and total length = 3+2+4+2+2+2 = 15 ticks (4+2+3 note ticks plus 2 gap ticks after each note).
- loop_en=1, len=2 {D/1, E/1} → pitch sequence 266, 237, 266, 237… and done never pulses. stop mid-note → next cycle busy=0 and note_valid=0.
- Entry pitch=0, dur=5 → note_valid=0 for 5 ticks while note_start still pulses. dur=0 → lasts 1 tick.
- start with cfg_len=0 → stays IDLE. start and stop in the same cycle → stays IDLE. cfg_we while busy → table unchanged, verified by replay.
- reset asserted mid-PLAY → all outputs 0 asynchronously. After release, start replays from index 0 with table intact.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM state, default widths,
// pitch maxval constants for the tone generator, and note-length presets.
package melody_pkg;

    localparam int unsigned PITCH_BW_DEF    = 9;
    localparam int unsigned DUR_BW_DEF      = 13;
    localparam int unsigned ADDR_BW_DEF     = 5;
    localparam int unsigned GAP_SAMPLES_DEF = 200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Sine-clock maxval per pitch; smaller value = higher tone
    localparam logic [PITCH_BW_DEF-1:0] NOTE_D     = 9'd266;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_E     = 9'd237;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_FIS   = 9'd211;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_G     = 9'd199;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_A     = 9'd177;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_B     = 9'd158;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_C     = 9'd149;
    localparam logic [PITCH_BW_DEF-1:0] NOTE_DHIGH = 9'd133;

    // Note lengths in fs samples at 8 kHz
    localparam logic [DUR_BW_DEF-1:0] DUR_EIGHTH        = 13'd2000;
    localparam logic [DUR_BW_DEF-1:0] DUR_QUARTER       = 13'd4000;
    localparam logic [DUR_BW_DEF-1:0] DUR_DOTTED_QUARTER = 13'd6000;
    localparam logic [DUR_BW_DEF-1:0] DUR_HALF          = 13'd8000;

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/config/status bundle between a host (master) and the melody sequencer (slave).
interface melody_sequencer_if
    import melody_pkg::*;
#(
    parameter int unsigned PITCH_BITWIDTH = PITCH_BW_DEF,
    parameter int unsigned DUR_BITWIDTH   = DUR_BW_DEF,
    parameter int unsigned ADDR_BITWIDTH  = ADDR_BW_DEF
);
    logic                      fs_tick;
    logic                      cfg_we;
    logic [ADDR_BITWIDTH-1:0]  cfg_addr;
    logic [PITCH_BITWIDTH-1:0] cfg_pitch;
    logic [DUR_BITWIDTH-1:0]   cfg_dur;
    logic [ADDR_BITWIDTH:0]    cfg_len;
    logic                      start;
    logic                      stop;
    logic                      loop_en;

    logic [PITCH_BITWIDTH-1:0] pitch_maxval;
    logic                      note_valid;
    logic                      note_start;
    logic [ADDR_BITWIDTH-1:0]  cur_index;
    logic                      busy;
    logic                      done;

    modport master (
        output fs_tick, cfg_we, cfg_addr, cfg_pitch, cfg_dur, cfg_len, start, stop, loop_en,
        input  pitch_maxval, note_valid, note_start, cur_index, busy, done
    );

    modport slave (
        input  fs_tick, cfg_we, cfg_addr, cfg_pitch, cfg_dur, cfg_len, start, stop, loop_en,
        output pitch_maxval, note_valid, note_start, cur_index, busy, done
    );

endinterface

// File: rtl/note_table.sv
// Note storage: synchronous write, registered read, no reset on the array or read register.
module note_table #(
    parameter int unsigned ADDR_BITWIDTH = 5,
    parameter int unsigned DATA_BITWIDTH = 22
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [ADDR_BITWIDTH-1:0] i_waddr,
    input  logic [DATA_BITWIDTH-1:0] i_wdata,
    input  logic                     i_re,
    input  logic [ADDR_BITWIDTH-1:0] i_raddr,
    output logic [DATA_BITWIDTH-1:0] o_rdata
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITWIDTH;

    logic [DATA_BITWIDTH-1:0] r_mem [DEPTH];
    logic [DATA_BITWIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through a runtime-loaded note table at sample rate, driving pitch maxval,
// a per-note restart strobe and a DAC gate to the tone datapath.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned PITCH_BITWIDTH = PITCH_BW_DEF,
    parameter int unsigned DUR_BITWIDTH   = DUR_BW_DEF,
    parameter int unsigned ADDR_BITWIDTH  = ADDR_BW_DEF,
    parameter int unsigned GAP_SAMPLES    = GAP_SAMPLES_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    melody_sequencer_if.slave bus
);
    localparam int unsigned ENTRY_BW = PITCH_BITWIDTH + DUR_BITWIDTH;
    localparam int unsigned LEN_BW   = ADDR_BITWIDTH + 1;
    localparam int unsigned GAP_BW   = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;
    localparam logic [GAP_BW-1:0] GAP_LAST = GAP_BW'((GAP_SAMPLES > 0) ? (GAP_SAMPLES - 1) : 0);
    localparam logic [LEN_BW-1:0] LEN_MAX  = LEN_BW'(2 ** ADDR_BITWIDTH);

    state_e                    r_state, w_state_next;
    logic [ADDR_BITWIDTH-1:0]  r_idx, w_idx_next;
    logic [LEN_BW-1:0]         r_len, w_len_next;
    logic                      r_loop, w_loop_next;
    logic [DUR_BITWIDTH-1:0]   r_cnt, w_cnt_next;
    logic [GAP_BW-1:0]         r_gap, w_gap_next;
    logic [PITCH_BITWIDTH-1:0] r_pitch, w_pitch_next;
    logic                      r_note_valid, w_note_valid_next;
    logic                      r_note_start, w_note_start_next;
    logic [ADDR_BITWIDTH-1:0]  r_cur_index, w_cur_index_next;
    logic                      r_busy;
    logic                      r_done, w_done_next;
    logic                      w_advance;

    logic [ENTRY_BW-1:0]       w_rdata;
    logic [PITCH_BITWIDTH-1:0] w_entry_pitch;
    logic [DUR_BITWIDTH-1:0]   w_entry_dur;
    logic [DUR_BITWIDTH-1:0]   w_dur_last;
    logic                      w_is_last;
    logic                      w_len_ok;
    logic                      w_rd_en;

    // Read is launched with the next index as the FSM enters FETCH, so the entry is
    // already on the read register during FETCH and lands on the outputs at PLAY entry.
    assign w_rd_en = (w_state_next == ST_FETCH);

    note_table #(
        .ADDR_BITWIDTH (ADDR_BITWIDTH),
        .DATA_BITWIDTH (ENTRY_BW)
    ) u_note_table (
        .i_clk   (i_clk),
        .i_we    (bus.cfg_we && (r_state == ST_IDLE)),
        .i_waddr (bus.cfg_addr),
        .i_wdata ({bus.cfg_pitch, bus.cfg_dur}),
        .i_re    (w_rd_en),
        .i_raddr (w_idx_next),
        .o_rdata (w_rdata)
    );

    assign w_entry_pitch = w_rdata[ENTRY_BW-1:DUR_BITWIDTH];
    assign w_entry_dur   = w_rdata[DUR_BITWIDTH-1:0];
    assign w_dur_last    = (w_entry_dur == '0) ? '0 : (w_entry_dur - DUR_BITWIDTH'(1));
    assign w_is_last     = ({1'b0, r_idx} == (r_len - LEN_BW'(1)));
    assign w_len_ok      = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);

    // Next-state and next-output logic
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_len_next        = r_len;
        w_loop_next       = r_loop;
        w_cnt_next        = r_cnt;
        w_gap_next        = r_gap;
        w_pitch_next      = r_pitch;
        w_note_valid_next = r_note_valid;
        w_note_start_next = 1'b0;
        w_cur_index_next  = r_cur_index;
        w_done_next       = 1'b0;
        w_advance         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && w_len_ok) begin
                    w_state_next = ST_FETCH;
                    w_idx_next   = '0;
                    w_len_next   = bus.cfg_len;
                    w_loop_next  = bus.loop_en;
                end
            end
            ST_FETCH: begin
                w_state_next      = ST_PLAY;
                w_pitch_next      = w_entry_pitch;
                w_note_valid_next = (w_entry_pitch != '0);
                w_note_start_next = 1'b1;
                w_cur_index_next  = r_idx;
                w_cnt_next        = '0;
            end
            ST_PLAY: begin
                // A tick in the PLAY entry cycle is not counted
                if (bus.fs_tick && !r_note_start) begin
                    if (r_cnt == w_dur_last) begin
                        w_note_valid_next = 1'b0;
                        if (GAP_SAMPLES > 0) begin
                            w_state_next = ST_GAP;
                            w_gap_next   = '0;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + DUR_BITWIDTH'(1);
                    end
                end
            end
            ST_GAP: begin
                if (bus.fs_tick) begin
                    if (r_gap == GAP_LAST) begin
                        w_advance = 1'b1;
                    end else begin
                        w_gap_next = r_gap + GAP_BW'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_advance) begin
            if (w_is_last && !r_loop) begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
            end else begin
                w_state_next = ST_FETCH;
                w_idx_next   = w_is_last ? '0 : (r_idx + ADDR_BITWIDTH'(1));
            end
        end

        // Abort wins over start and over a note ending in the same cycle
        if (bus.stop) begin
            w_state_next      = ST_IDLE;
            w_pitch_next      = r_pitch;
            w_cur_index_next  = r_cur_index;
            w_note_valid_next = 1'b0;
            w_note_start_next = 1'b0;
            w_done_next       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_loop       <= 1'b0;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_pitch      <= '0;
            r_note_valid <= 1'b0;
            r_note_start <= 1'b0;
            r_cur_index  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_len        <= w_len_next;
            r_loop       <= w_loop_next;
            r_cnt        <= w_cnt_next;
            r_gap        <= w_gap_next;
            r_pitch      <= w_pitch_next;
            r_note_valid <= w_note_valid_next;
            r_note_start <= w_note_start_next;
            r_cur_index  <= w_cur_index_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= w_done_next;
        end
    end

    assign bus.pitch_maxval = r_pitch;
    assign bus.note_valid   = r_note_valid;
    assign bus.note_start   = r_note_start;
    assign bus.cur_index    = r_cur_index;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: one legato instance (GAP=0) and one with GAP=2,
// both driven by the same host stimulus; expected notes are queued at start and popped on note_start.
module tb_melody_sequencer;
    import melody_pkg::*;

    localparam int unsigned PW = 9;
    localparam int unsigned DW = 13;
    localparam int unsigned AW = 5;
    localparam int unsigned LW = AW + 1;
    localparam int TICK_PERIOD = 5;

    typedef struct {
        logic [PW-1:0] pitch;
        logic          valid;
        logic [AW-1:0] idx;
        int            ticks;
        int            muted;
    } exp_note_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fs_tick = 1'b0;
    logic cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [PW-1:0] cfg_pitch = '0;
    logic [DW-1:0] cfg_dur = '0;
    logic [LW-1:0] cfg_len = '0;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic loop_en = 1'b0;

    int errors = 0;
    int checks = 0;
    int tick_ph = 0;
    bit sel = 1'b0;

    exp_note_t sb[$];
    logic [PW-1:0] tbl_p [32];
    logic [DW-1:0] tbl_d [32];

    melody_sequencer_if #(.PITCH_BITWIDTH(PW), .DUR_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus0 ();
    melody_sequencer_if #(.PITCH_BITWIDTH(PW), .DUR_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus2 ();

    melody_sequencer #(.PITCH_BITWIDTH(PW), .DUR_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .GAP_SAMPLES(0))
        dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    melody_sequencer #(.PITCH_BITWIDTH(PW), .DUR_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .GAP_SAMPLES(2))
        dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

    assign bus0.fs_tick = fs_tick;   assign bus2.fs_tick = fs_tick;
    assign bus0.cfg_we = cfg_we;     assign bus2.cfg_we = cfg_we;
    assign bus0.cfg_addr = cfg_addr; assign bus2.cfg_addr = cfg_addr;
    assign bus0.cfg_pitch = cfg_pitch; assign bus2.cfg_pitch = cfg_pitch;
    assign bus0.cfg_dur = cfg_dur;   assign bus2.cfg_dur = cfg_dur;
    assign bus0.cfg_len = cfg_len;   assign bus2.cfg_len = cfg_len;
    assign bus0.start = start;       assign bus2.start = start;
    assign bus0.stop = stop;         assign bus2.stop = stop;
    assign bus0.loop_en = loop_en;   assign bus2.loop_en = loop_en;

    logic [PW-1:0] m_pitch;
    logic          m_valid, m_nstart, m_busy, m_done;
    logic [AW-1:0] m_idx;
    assign m_pitch  = sel ? bus2.pitch_maxval : bus0.pitch_maxval;
    assign m_valid  = sel ? bus2.note_valid   : bus0.note_valid;
    assign m_nstart = sel ? bus2.note_start   : bus0.note_start;
    assign m_idx    = sel ? bus2.cur_index    : bus0.cur_index;
    assign m_busy   = sel ? bus2.busy         : bus0.busy;
    assign m_done   = sel ? bus2.done         : bus0.done;

    always #5 clk = ~clk;

    // Sample strobe: one cycle high every TICK_PERIOD cycles
    always @(posedge clk) begin
        #1;
        if (tick_ph == TICK_PERIOD - 1) begin
            fs_tick = 1'b1;
            tick_ph = 0;
        end else begin
            fs_tick = 1'b0;
            tick_ph = tick_ph + 1;
        end
    end

    task automatic write_entry(input int a, input logic [PW-1:0] p, input logic [DW-1:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_pitch = p; cfg_dur = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tbl_p[a] = p;
        tbl_d[a] = d;
    endtask

    task automatic push_expect(input int len, input int gap, input int nev);
        exp_note_t e;
        int i, dur_eff;
        for (int k = 0; k < nev; k++) begin
            i = k % len;
            dur_eff = (tbl_d[i] == '0) ? 1 : int'(tbl_d[i]);
            e.pitch = tbl_p[i];
            e.valid = (tbl_p[i] != '0);
            e.idx   = AW'(i);
            e.ticks = dur_eff + gap;
            e.muted = e.valid ? gap : dur_eff + gap;
            sb.push_back(e);
        end
    endtask

    // Start is issued the cycle after a tick so no tick lands in FETCH or PLAY entry
    task automatic pulse_start(input int len, input logic lp);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!fs_tick && guard < 3 * TICK_PERIOD) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        start = 1'b1; cfg_len = LW'(len); loop_en = lp;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
    endtask

    task automatic run_melody(input bit dsel, input bit exp_done, input int budget, output int total);
        exp_note_t e;
        int ticks, muted, cyc, exp_ticks, exp_muted;
        bit seen, fin;
        sel = dsel; ticks = 0; muted = 0; cyc = 0; seen = 0; fin = 0; total = 0;
        exp_ticks = 0; exp_muted = 0;
        while (!fin && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (m_nstart) begin
                if (seen) begin
                    checks++;
                    if (ticks !== exp_ticks) begin
                        errors++;
                        $display("FAIL note_len: got %0d ticks, expected %0d", ticks, exp_ticks);
                    end
                    checks++;
                    if (muted !== exp_muted) begin
                        errors++;
                        $display("FAIL muted_ticks: got %0d, expected %0d", muted, exp_muted);
                    end
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_note: note_start with pitch=%0d, expected none", m_pitch);
                    fin = 1;
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (m_pitch !== e.pitch) begin
                        errors++;
                        $display("FAIL pitch: got %0d, expected %0d", m_pitch, e.pitch);
                    end
                    checks++;
                    if (m_valid !== e.valid) begin
                        errors++;
                        $display("FAIL note_valid: got %0b, expected %0b", m_valid, e.valid);
                    end
                    checks++;
                    if (m_idx !== e.idx) begin
                        errors++;
                        $display("FAIL cur_index: got %0d, expected %0d", m_idx, e.idx);
                    end
                    exp_ticks = e.ticks; exp_muted = e.muted;
                    ticks = 0; muted = 0; seen = 1;
                    if (!exp_done && sb.size() == 0) fin = 1;
                end
            end else if (fs_tick && seen) begin
                ticks++; total++;
                if (!m_valid) muted++;
            end
            if (m_done && !fin) begin
                checks++;
                if (!exp_done) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1, expected 0");
                end else begin
                    if (ticks !== exp_ticks || muted !== exp_muted || m_busy !== 1'b0 || sb.size() != 0) begin
                        errors++;
                        $display("FAIL done_timing: ticks=%0d muted=%0d busy=%0b left=%0d, expected ticks=%0d muted=%0d busy=0 left=0",
                                 ticks, muted, m_busy, sb.size(), exp_ticks, exp_muted);
                    end
                end
                fin = 1;
            end
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL timeout: melody not finished after %0d cycles, %0d notes outstanding", budget, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_all_zero(input string name);
        logic [PW+AW+3:0] obs;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            obs = {m_pitch, m_valid, m_nstart, m_idx, m_busy, m_done};
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL %s dut%0d: outputs=%h, expected 0", name, s * 2, obs);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int total;
        write_entry(0, NOTE_G, 13'd4);
        write_entry(1, NOTE_A, 13'd2);
        write_entry(2, NOTE_B, 13'd3);
        push_expect(3, 0, 3);
        pulse_start(3, 1'b0);
        run_melody(1'b0, 1'b1, 400, total);
        checks++;
        if (total !== 9) begin
            errors++;
            $display("FAIL basic_total: got %0d ticks, expected 9", total);
        end
    endtask

    task automatic test_gap();
        int total;
        pulse_stop();
        push_expect(3, 2, 3);
        pulse_start(3, 1'b0);
        run_melody(1'b1, 1'b1, 600, total);
        checks++;
        if (total !== 15) begin
            errors++;
            $display("FAIL gap_total: got %0d ticks, expected 15", total);
        end
    endtask

    task automatic test_latency();
        pulse_stop();
        sel = 1'b0;
        pulse_start(3, 1'b0);
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b1 || m_nstart !== 1'b0) begin
            errors++;
            $display("FAIL fetch_cycle: busy=%0b note_start=%0b, expected busy=1 note_start=0", m_busy, m_nstart);
        end
        @(negedge clk);
        checks++;
        if (m_nstart !== 1'b1 || m_pitch !== NOTE_G || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL play_entry: note_start=%0b pitch=%0d valid=%0b, expected 1/199/1", m_nstart, m_pitch, m_valid);
        end
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_done !== 1'b0 || m_pitch !== NOTE_G) begin
            errors++;
            $display("FAIL stop_play: busy=%0b valid=%0b done=%0b pitch=%0d, expected 0/0/0/199",
                     m_busy, m_valid, m_done, m_pitch);
        end
    endtask

    task automatic test_loop();
        int total;
        bit saw_done;
        pulse_stop();
        write_entry(0, NOTE_D, 13'd1);
        write_entry(1, NOTE_E, 13'd1);
        push_expect(2, 0, 5);
        pulse_start(2, 1'b1);
        loop_en = 1'b0;
        run_melody(1'b0, 1'b0, 400, total);
        saw_done = 1'b0;
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        @(negedge clk);
        if (m_done) saw_done = 1'b1;
        checks++;
        if (m_busy !== 1'b0 || m_valid !== 1'b0 || saw_done || m_pitch !== NOTE_D) begin
            errors++;
            $display("FAIL loop_stop: busy=%0b valid=%0b done=%0b pitch=%0d, expected 0/0/0/266",
                     m_busy, m_valid, saw_done, m_pitch);
        end
    endtask

    task automatic test_rest();
        int total;
        pulse_stop();
        write_entry(0, 9'd0, 13'd5);
        write_entry(1, NOTE_C, 13'd0);
        push_expect(2, 0, 2);
        pulse_start(2, 1'b0);
        run_melody(1'b0, 1'b1, 400, total);
        checks++;
        if (total !== 6) begin
            errors++;
            $display("FAIL rest_total: got %0d ticks, expected 6", total);
        end
    endtask

    task automatic test_we_busy();
        int total;
        pulse_stop();
        push_expect(2, 0, 1);
        pulse_start(2, 1'b0);
        run_melody(1'b0, 1'b0, 200, total);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = '0; cfg_pitch = NOTE_DHIGH; cfg_dur = 13'd3;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        pulse_stop();
        push_expect(2, 0, 2);
        pulse_start(2, 1'b0);
        run_melody(1'b0, 1'b1, 400, total);
    endtask

    task automatic test_ignored();
        int lens[3] = '{0, 33, 2};
        sel = 1'b0;
        pulse_stop();
        foreach (lens[k]) begin
            @(posedge clk); #1;
            start = 1'b1; cfg_len = LW'(lens[k]); loop_en = 1'b0;
            stop = (k == 2);
            @(posedge clk); #1;
            start = 1'b0; stop = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (m_busy !== 1'b0 || m_nstart !== 1'b0) begin
                errors++;
                $display("FAIL ignored_start len=%0d stop=%0b: busy=%0b note_start=%0b, expected 0/0",
                         lens[k], (k == 2), m_busy, m_nstart);
            end
        end
    endtask

    task automatic test_reset_mid();
        int total;
        pulse_stop();
        write_entry(0, NOTE_G, 13'd4);
        write_entry(1, NOTE_A, 13'd2);
        write_entry(2, NOTE_B, 13'd3);
        push_expect(3, 0, 1);
        pulse_start(3, 1'b0);
        run_melody(1'b0, 1'b0, 200, total);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk); #1; rst_n = 1'b1;
        push_expect(3, 0, 3);
        pulse_start(3, 1'b0);
        run_melody(1'b0, 1'b1, 400, total);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_latency();
        test_loop();
        test_rest();
        test_we_busy();
        test_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
